// File: rtl/trsq8_pkg.sv
// trsq8_pkg: definitions shared by the TRSQ8 instruction-fetch slice.
//   PC_W / INST_W          : program-counter and instruction word widths.
//   RESET_VECTOR_DEF       : default PC after reset.
//   IRQ_VECTOR_DEF         : default interrupt entry address (TRSQ8_IRQ_EN builds).
//   redirect_t             : which redirect, if any, the fetch unit acts on this cycle.
//   pc_inc()               : PC + 1 with natural 13-bit wrap (8191 -> 0).
package trsq8_pkg;

    localparam int PC_W   = 13;
    localparam int INST_W = 15;

    localparam logic [PC_W-1:0] RESET_VECTOR_DEF = 13'd0;
    localparam logic [PC_W-1:0] IRQ_VECTOR_DEF   = 13'd4;

    typedef enum logic [2:0] {
        RD_NONE = 3'd0,
        RD_JMP  = 3'd1,
        RD_CALL = 3'd2,
        RD_RET  = 3'd3,
        RD_IRQ  = 3'd4
    } redirect_t;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_ret_stack.sv
// ret_stack: LIFO of return addresses for the TRSQ8 fetch unit.
//   clk, rst  : clock (rising edge), synchronous active-high reset of sp only.
//   push, din : write din at mem[sp] and increment sp (ignored when full).
//   pop       : decrement sp (ignored when empty).
//   dout      : top of stack, mem[sp-1]; meaningless while empty.
//   full      : sp == DEPTH.   empty : sp == 0.   sp : current fill level.
//   ovf / unf : single-cycle pulses for a push while full / pop while empty.
// The caller never asserts push and pop together.
module ret_stack
    import trsq8_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int SP_W  = $clog2(DEPTH + 1),
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            full,
    output logic            empty,
    output logic [SP_W-1:0] sp,
    output logic            ovf,
    output logic            unf
);

    logic [PC_W-1:0] mem [DEPTH];
    logic [SP_W-1:0] sp_m1;

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);
    assign sp_m1 = sp - SP_W'(1);
    assign dout  = mem[sp_m1[IDX_W-1:0]];
    assign ovf   = push && full;
    assign unf   = pop && empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end
    end

    // Storage is deliberately not reset; only sp defines what is live.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[sp[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the TRSQ8 core.
// Owns the 13-bit PC, presents it to a combinational program ROM and registers
// the returned 15-bit word for the decoder. Handles JMP/CALL/RET redirects with
// a hardware return stack (ret_stack).
// Optional feature macro: TRSQ8_IRQ_EN (adds IRQ_ip / IN_ISR_op and IRQ entry).
// Ports:
//   CLK_ip, RST_ip     : clock, synchronous active-high reset.
//   ROM_ADDR_op        : ROM address, always the PC register.
//   ROM_DATA_ip        : ROM word for ROM_ADDR_op, same cycle.
//   INST_op, INST_PC_op, VALID_op : registered instruction, its address, live flag.
//   STALL_ip           : hold request from decode/execute.
//   JMP_ip, CALL_ip, RET_ip, TARGET_ip : redirect requests (RET > CALL > JMP).
//   STK_OVF_op, STK_UNF_op : sticky stack overflow / underflow, cleared by reset.
//   IRQ_ip, IN_ISR_op  : interrupt request / in-service flag (TRSQ8_IRQ_EN only).
//
// Handshake: a word is handed to the decoder on every cycle VALID_op is high.
// STALL_ip holds the current word (and PC) for as long as it is high. Redirect
// requests are only honoured while VALID_op is high, because they come from the
// decoder acting on that word; a redirect overrides a stall and squashes the
// word fetched from the stale PC (VALID_op low for one cycle).
module fetch_ctrl
    import trsq8_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int              STACK_DEPTH  = 8
`ifdef TRSQ8_IRQ_EN
    ,
    parameter logic [PC_W-1:0] IRQ_VECTOR   = IRQ_VECTOR_DEF
`endif
) (
    input  logic              CLK_ip,
    input  logic              RST_ip,
    output logic [PC_W-1:0]   ROM_ADDR_op,
    input  logic [INST_W-1:0] ROM_DATA_ip,
    output logic [INST_W-1:0] INST_op,
    output logic              VALID_op,
    output logic [PC_W-1:0]   INST_PC_op,
    input  logic              STALL_ip,
    input  logic              JMP_ip,
    input  logic              CALL_ip,
    input  logic              RET_ip,
    input  logic [PC_W-1:0]   TARGET_ip,
    output logic              STK_OVF_op,
    output logic              STK_UNF_op
`ifdef TRSQ8_IRQ_EN
    ,
    input  logic              IRQ_ip,
    output logic              IN_ISR_op
`endif
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    redirect_t       rd_sel;

    logic            stk_push;
    logic            stk_pop;
    logic [PC_W-1:0] stk_din;
    logic [PC_W-1:0] stk_dout;
    logic            stk_full;
    logic            stk_empty;
    logic [SP_W-1:0] stk_sp;
    logic            stk_ovf_pulse;
    logic            stk_unf_pulse;
    logic            stk_status_unused;

    assign ROM_ADDR_op = pc;

    // Fill level and full flag are carried for visibility only; the stack
    // itself decides whether a push lands.
    assign stk_status_unused = ^{stk_sp, stk_full};

    // Redirect selection: RET > CALL > JMP, all gated by VALID_op.
    always_comb begin
        rd_sel = RD_NONE;
        if (VALID_op) begin
            if (RET_ip) begin
                rd_sel = RD_RET;
            end else if (CALL_ip) begin
                rd_sel = RD_CALL;
            end else if (JMP_ip) begin
                rd_sel = RD_JMP;
            end
        end
`ifdef TRSQ8_IRQ_EN
        // An interrupt only enters on an otherwise quiet, unstalled cycle.
        if (rd_sel == RD_NONE && IRQ_ip && !IN_ISR_op && !STALL_ip) begin
            rd_sel = RD_IRQ;
        end
`endif
    end

    // Reset discards any redirect in the same cycle, including stack traffic.
    always_comb begin
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (!RST_ip) begin
            stk_push = (rd_sel == RD_CALL);
`ifdef TRSQ8_IRQ_EN
            stk_push = stk_push || (rd_sel == RD_IRQ);
`endif
            stk_pop  = (rd_sel == RD_RET);
        end
    end

    // CALL returns to the instruction after the call; an interrupt returns to
    // the next unfetched address, which is the current PC.
    always_comb begin
        stk_din = pc_inc(INST_PC_op);
`ifdef TRSQ8_IRQ_EN
        if (rd_sel == RD_IRQ) begin
            stk_din = pc;
        end
`endif
    end

    always_comb begin
        pc_next = pc;
        unique case (rd_sel)
            RD_NONE: begin
                if (!STALL_ip) begin
                    pc_next = pc_inc(pc);
                end
            end
            RD_JMP,
            RD_CALL: pc_next = TARGET_ip;
            RD_RET:  pc_next = stk_empty ? RESET_VECTOR : stk_dout;
`ifdef TRSQ8_IRQ_EN
            RD_IRQ:  pc_next = IRQ_VECTOR;
`endif
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge CLK_ip) begin
        if (RST_ip) begin
            pc         <= RESET_VECTOR;
            INST_op    <= '0;
            VALID_op   <= 1'b0;
            INST_PC_op <= '0;
            STK_OVF_op <= 1'b0;
            STK_UNF_op <= 1'b0;
        end else begin
            pc         <= pc_next;
            STK_OVF_op <= STK_OVF_op | stk_ovf_pulse;
            STK_UNF_op <= STK_UNF_op | stk_unf_pulse;
            if (rd_sel == RD_NONE) begin
                if (!STALL_ip) begin
                    INST_op    <= ROM_DATA_ip;
                    INST_PC_op <= pc;
                    VALID_op   <= 1'b1;
                end
            end else begin
                // Squash the word fetched from the stale PC.
                VALID_op <= 1'b0;
            end
        end
    end

`ifdef TRSQ8_IRQ_EN
    always_ff @(posedge CLK_ip) begin
        if (RST_ip) begin
            IN_ISR_op <= 1'b0;
        end else if (rd_sel == RD_IRQ) begin
            IN_ISR_op <= 1'b1;
        end else if (rd_sel == RD_RET) begin
            IN_ISR_op <= 1'b0;
        end
    end
`endif

    ret_stack #(
        .DEPTH(STACK_DEPTH)
    ) u_ret_stack (
        .clk   (CLK_ip),
        .rst   (RST_ip),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .sp    (stk_sp),
        .ovf   (stk_ovf_pulse),
        .unf   (stk_unf_pulse)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: ROM model returns {2'b01, address}; a vector table
// drives redirect/stall scenarios, and every expected result is queued when
// the stimulus is applied and compared after the clock edge.
module tb_fetch_ctrl;
  import trsq8_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] rom_addr;
  logic [14:0] rom_data;
  logic [14:0] inst;
  logic        valid;
  logic [12:0] inst_pc;
  logic        stall, jmp, call, ret;
  logic [12:0] target;
  logic        stk_ovf, stk_unf;
`ifdef TRSQ8_IRQ_EN
  logic        irq;
  logic        in_isr;
`endif

  int checks = 0;
  int errors = 0;

  // expected {valid, inst_pc[12:0], ovf, unf}
  logic [15:0] exp_q[$];

  typedef struct {
    logic        s, j, c, r;
    logic [12:0] tgt;
    logic        ev;
    logic [12:0] epc;
    logic        eo, eu;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] rom_word(input logic [12:0] a);
    return {2'b01, a};
  endfunction

  assign rom_data = rom_word(rom_addr);

  fetch_ctrl dut (
    .CLK_ip      (clk),
    .RST_ip      (rst),
    .ROM_ADDR_op (rom_addr),
    .ROM_DATA_ip (rom_data),
    .INST_op     (inst),
    .VALID_op    (valid),
    .INST_PC_op  (inst_pc),
    .STALL_ip    (stall),
    .JMP_ip      (jmp),
    .CALL_ip     (call),
    .RET_ip      (ret),
    .TARGET_ip   (target),
    .STK_OVF_op  (stk_ovf),
    .STK_UNF_op  (stk_unf)
`ifdef TRSQ8_IRQ_EN
    ,
    .IRQ_ip      (irq),
    .IN_ISR_op   (in_isr)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  function automatic vec_t v(input logic s, j, c, r, input int tgt,
                             input logic ev, input int epc, input logic eo, eu);
    vec_t x;
    x.s = s; x.j = j; x.c = c; x.r = r;
    x.tgt = 13'(tgt);
    x.ev = ev; x.epc = 13'(epc); x.eo = eo; x.eu = eu;
    return x;
  endfunction

  task automatic compare(input string name);
    logic [15:0] e;
    logic [12:0] epc;
    logic [12:0] enext;
    logic ok;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, required an expected entry", name);
    end else begin
      e = exp_q.pop_front();
      epc = e[14:2];
      enext = epc + 13'd1;
      ok = (valid === e[15]) && (stk_ovf === e[1]) && (stk_unf === e[0]);
      if (e[15]) begin
        ok = ok && (inst_pc === epc) && (inst === rom_word(epc)) && (rom_addr === enext);
      end
      if (!ok) begin
        errors++;
        $display("FAIL %s: got valid=%0b inst_pc=%0d inst=%h addr=%0d ovf=%0b unf=%0b; required valid=%0b inst_pc=%0d inst=%h addr=%0d ovf=%0b unf=%0b",
                 name, valid, inst_pc, inst, rom_addr, stk_ovf, stk_unf,
                 e[15], epc, rom_word(epc), enext, e[1], e[0]);
      end
    end
  endtask

  // Driver: apply inputs, queue the expectation, clock, then compare.
  task automatic drive(input logic s, j, c, r, input logic [12:0] t,
                       input logic ev, input logic [12:0] epc, input logic eo, eu,
                       input string name);
    stall = s; jmp = j; call = c; ret = r; target = t;
    exp_q.push_back({ev, epc, eo, eu});
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (valid !== 1'b0 || inst !== 15'd0 || inst_pc !== 13'd0 || rom_addr !== 13'd0 ||
        stk_ovf !== 1'b0 || stk_unf !== 1'b0) begin
      errors++;
      $display("FAIL %s: got valid=%0b inst=%h inst_pc=%0d addr=%0d ovf=%0b unf=%0b; required all zero",
               name, valid, inst, inst_pc, rom_addr, stk_ovf, stk_unf);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0b required %0b", name, got, want);
    end
  endtask

  initial begin
    int epc;
    rst = 1'b1; stall = 0; jmp = 0; call = 0; ret = 0; target = '0;
`ifdef TRSQ8_IRQ_EN
    irq = 1'b0;
`endif

    // {stall, jmp, call, ret, target, exp valid, exp inst_pc, exp ovf, exp unf}
    vecs.push_back(v(0,0,0,0,   0, 1,    0, 0,0)); // 0 first fetch
    vecs.push_back(v(0,0,0,0,   0, 1,    1, 0,0));
    vecs.push_back(v(0,0,0,0,   0, 1,    2, 0,0));
    vecs.push_back(v(0,0,0,0,   0, 1,    3, 0,0));
    vecs.push_back(v(0,0,0,0,   0, 1,    4, 0,0));
    vecs.push_back(v(0,0,0,0,   0, 1,    5, 0,0)); // 5
    vecs.push_back(v(0,1,0,0, 100, 0,    0, 0,0)); // JMP 100 at 5
    vecs.push_back(v(0,0,0,0,   0, 1,  100, 0,0));
    vecs.push_back(v(0,0,0,0,   0, 1,  101, 0,0));
    vecs.push_back(v(0,1,0,0,   9, 0,    0, 0,0));
    vecs.push_back(v(0,0,0,0,   0, 1,    9, 0,0)); // 10
    vecs.push_back(v(0,0,0,0,   0, 1,   10, 0,0));
    vecs.push_back(v(0,0,1,0, 200, 0,    0, 0,0)); // CALL 200 at 10
    vecs.push_back(v(0,0,0,0,   0, 1,  200, 0,0));
    vecs.push_back(v(0,0,0,0,   0, 1,  201, 0,0));
    vecs.push_back(v(0,0,0,1,   0, 0,    0, 0,0)); // 15 RET at 201
    vecs.push_back(v(0,0,0,0,   0, 1,   11, 0,0));
    vecs.push_back(v(0,0,0,0,   0, 1,   12, 0,0));
    vecs.push_back(v(0,1,0,0,  20, 0,    0, 0,0));
    vecs.push_back(v(0,0,0,0,   0, 1,   20, 0,0));
    vecs.push_back(v(1,0,0,0,   0, 1,   20, 0,0)); // 20 stall x3
    vecs.push_back(v(1,0,0,0,   0, 1,   20, 0,0));
    vecs.push_back(v(1,0,0,0,   0, 1,   20, 0,0));
    vecs.push_back(v(0,0,0,0,   0, 1,   21, 0,0));
    vecs.push_back(v(1,1,0,0,  50, 0,    0, 0,0)); // JMP overrides stall
    vecs.push_back(v(0,0,0,0,   0, 1,   50, 0,0)); // 25
    vecs.push_back(v(0,0,1,0, 300, 0,    0, 0,0)); // CALL, sp=1
    vecs.push_back(v(0,0,0,0,   0, 1,  300, 0,0));
    vecs.push_back(v(0,0,1,1, 400, 0,    0, 0,0)); // CALL+RET: RET wins
    vecs.push_back(v(0,0,0,0,   0, 1,   51, 0,0));
    vecs.push_back(v(0,0,0,1,   0, 0,    0, 0,1)); // 30 RET on empty
    vecs.push_back(v(0,0,0,0,   0, 1,    0, 0,1));
    vecs.push_back(v(0,1,0,0,  60, 0,    0, 0,1));
    vecs.push_back(v(0,1,0,0, 700, 1,   60, 0,1)); // JMP ignored in bubble
    vecs.push_back(v(0,0,0,0,   0, 1,   61, 0,1));
    vecs.push_back(v(0,1,1,0,  80, 0,    0, 0,1)); // 35 CALL beats JMP
    vecs.push_back(v(0,0,0,0,   0, 1,   80, 0,1));
    vecs.push_back(v(0,0,0,1,   0, 0,    0, 0,1));
    vecs.push_back(v(0,0,0,0,   0, 1,   62, 0,1));
    vecs.push_back(v(0,1,0,0,8190, 0,    0, 0,1));
    vecs.push_back(v(0,0,0,0,   0, 1, 8190, 0,1)); // 40
    vecs.push_back(v(0,0,0,0,   0, 1, 8191, 0,1));
    vecs.push_back(v(0,0,0,0,   0, 1,    0, 0,1)); // wrap
    vecs.push_back(v(0,0,0,0,   0, 1,    1, 0,1));

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_state");
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].j, vecs[i].c, vecs[i].r, vecs[i].tgt,
            vecs[i].ev, vecs[i].epc, vecs[i].eo, vecs[i].eu, $sformatf("vec%0d", i));
    end

`ifdef TRSQ8_IRQ_EN
    drive(0,1,0,0, 13'd30, 0, 13'd0, 0,1, "irq_jmp30");
    drive(0,0,0,0, 13'd0,  1, 13'd30, 0,1, "irq_at30");
    irq = 1'b1;
    drive(0,0,0,0, 13'd0,  0, 13'd0, 0,1, "irq_take");
    irq = 1'b0;
    check_bit("in_isr_set", in_isr, 1'b1);
    drive(0,0,0,0, 13'd0,  1, 13'd4, 0,1, "irq_vector");
    drive(0,0,0,0, 13'd0,  1, 13'd5, 0,1, "irq_body");
    drive(0,0,0,1, 13'd0,  0, 13'd0, 0,1, "irq_ret");
    check_bit("in_isr_clr", in_isr, 1'b0);
    drive(0,0,0,0, 13'd0,  1, 13'd31, 0,1, "irq_resume");
`endif

    // Reset mid-operation with a redirect pending: redirect must be discarded
    // and sticky flags cleared.
    rst = 1'b1; jmp = 1'b1; call = 1'b1; target = 13'd777;
    @(posedge clk);
    #1;
    check_reset("reset_mid_op");
    rst = 1'b0; jmp = 1'b0; call = 1'b0;

    // Nine nested CALLs into an 8-deep stack, then nine RETs.
    drive(0,0,0,0, 13'd0, 1, 13'd0, 0,0, "nest_start");
    for (int i = 0; i < 9; i++) begin
      drive(0,0,1,0, 13'(1000 + 16*i), 0, 13'd0, (i == 8), 0, $sformatf("nest_call%0d", i));
      drive(0,0,0,0, 13'd0, 1, 13'(1000 + 16*i), (i == 8), 0, $sformatf("nest_tgt%0d", i));
    end
    for (int k = 0; k < 8; k++) begin
      epc = (k == 7) ? 1 : 1000 + 16*(6 - k) + 1;
      drive(0,0,0,1, 13'd0, 0, 13'd0, 1, 0, $sformatf("nest_ret%0d", k));
      drive(0,0,0,0, 13'd0, 1, 13'(epc), 1, 0, $sformatf("nest_back%0d", k));
    end
    drive(0,0,0,1, 13'd0, 0, 13'd0, 1, 1, "nest_ret_unf");
    drive(0,0,0,0, 13'd0, 1, 13'd0, 1, 1, "nest_unf_pc0");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
